// File: rtl/serial_mag_compare_if.sv
// serial_mag_compare_if: operand request and one-hot result response channels of the bit-serial comparator
interface serial_mag_compare_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic             res_eq;
  logic             res_gt;
  logic             res_lt;
  logic [CNT_W-1:0] cycles;
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, res_eq, res_gt, res_lt, cycles
  );
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, res_eq, res_gt, res_lt, cycles
  );
endinterface

// File: rtl/serial_mag_compare.sv
// serial_mag_compare: MSB-first bit-serial magnitude comparator with valid/ready request and response.
// Define SERIAL_CMP_SIGNED_EN to compare operands as two's complement.
module serial_mag_compare #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic                clk,
  input logic                rst,
  serial_mag_compare_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;
  state_t           state, state_nx;
  logic [WIDTH-1:0] sa, sb;
  logic [CNT_W-1:0] bit_cnt, cnt;
  logic             r_eq, r_gt, r_lt, vld;
  logic             diff, last, a_wins;
  always_comb begin
    diff = sa[WIDTH-1] ^ sb[WIDTH-1];
    last = bit_cnt == '0;
`ifdef SERIAL_CMP_SIGNED_EN
    // on the sign bit a set bit means the smaller value
    a_wins = (cnt == '0) ? sb[WIDTH-1] : sa[WIDTH-1];
`else
    a_wins = sa[WIDTH-1];
`endif
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.in_valid ? CMP : IDLE;
      CMP:     state_nx = (diff || last) ? DONE : CMP;
      DONE:    state_nx = (vld && bus.out_ready) ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sa      <= '0;
      sb      <= '0;
      bit_cnt <= '0;
      cnt     <= '0;
      r_eq    <= 1'b0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
      vld     <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.in_valid) begin
        sa      <= bus.a;
        sb      <= bus.b;
        bit_cnt <= CNT_W'(WIDTH - 1);
        cnt     <= '0;
      end
      if (state == CMP) begin
        sa      <= sa << 1;
        sb      <= sb << 1;
        bit_cnt <= bit_cnt - 1'b1;
        cnt     <= cnt + 1'b1;
        if (diff || last) begin
          r_eq <= !diff;
          r_gt <= diff && a_wins;
          r_lt <= diff && !a_wins;
        end
      end
      // result is presented one clock after the decision is registered
      vld <= state == DONE && !(vld && bus.out_ready);
    end
  end
  assign bus.in_ready  = state == IDLE;
  assign bus.out_valid = vld;
  assign bus.res_eq    = vld && r_eq;
  assign bus.res_gt    = vld && r_gt;
  assign bus.res_lt    = vld && r_lt;
  assign bus.cycles    = cnt;
endmodule
